fwd_select_ctrl: RTL and testbench
==================================

Name: fwd_select_ctrl

Overview:
- Produces the 2-bit `select` codes consumed by the two 16-bit 4:1 EX-stage operand muxes of the 6-stage pipeline (IF, ID, RR, EX, MEM, WB).
- Tracks the destination-register scoreboard of the three instructions ahead of the issuing one and picks the youngest matching producer per operand.
- Raises a load-use stall when forwarding cannot cover the hazard.
- Sits beside the RR/EX pipeline register. The select outputs are registered so they are valid for the whole EX cycle.

Parameters:
- REG_AW, 3, register-address width (8 architectural registers).
- ZERO_REG_HW, 1, when 1 register 0 never forwards and never stalls.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high.
- issue_valid  input  1  RR stage holds a valid instruction that wants to enter EX.
- issue_src_a  input  REG_AW  operand A source register.
- issue_src_b  input  REG_AW  operand B source register.
- issue_use_a  input  1  operand A is read from the register file.
- issue_use_b  input  1  operand B is read from the register file.
- issue_dst  input  REG_AW  destination register.
- issue_wr_en  input  1  instruction writes issue_dst.
- issue_is_load  input  1  result is only available after MEM.
- flush  input  1  kill the issuing instruction (branch redirect).
- sel_a  output  2  operand A mux select, valid during EX.
- sel_b  output  2  operand B mux select, valid during EX.
- stall  output  1  hold IF/ID/RR this cycle; a bubble enters EX.

Behaviour:
- Scoreboard: three slots S_EX, S_MEM, S_WB. Each slot holds {valid, dst, wr_en, is_load}.
- Every clock the slots shift: S_WB <= S_MEM, S_MEM <= S_EX.
- S_EX <= issuing entry when issue_valid & !stall & !flush; otherwise S_EX <= bubble (valid=0).
- Match for operand X against slot S: use_X & S.valid & S.wr_en & (S.dst == src_X), excluding dst==0 when ZERO_REG_HW=1.
- Select encoding (meaning in the EX cycle):
  - 00 = register-file data (no match).
  - 01 = MEM-stage result (matched S_EX).
  - 10 = WB-stage result (matched S_MEM).
  - 11 = post-WB hold register (matched S_WB).
- Priority: S_EX > S_MEM > S_WB. The youngest producer wins.
- sel_a/sel_b are computed from the current slots and issue inputs, then registered at the clock edge. Latency is 1 cycle: issue in cycle N, select valid in cycle N+1.
- Load-use stall, combinational:
  - stall = issue_valid & !flush & (matchA(S_EX) | matchB(S_EX)) & S_EX.is_load.
  - No stall for a load matched in S_MEM or S_WB.
- During a stall the RR inputs are held by upstream logic. A bubble enters S_EX, and next cycle the load sits in S_MEM, so forwarding resolves with select 10.
- When stall=1, flush=1, or issue_valid=0, the registered selects are loaded with 00 (bubble in EX).
- flush and stall asserted together: flush wins, stall=0.
- Reset (synchronous): all slot valid bits clear, sel_a=sel_b=00. stall is forced 0 while reset is high.
- Reset asserted mid-stall: the stall drops in the same cycle and the scoreboard empties on the next edge.
- src_a==src_b: both operands get identical selects. No width arithmetic; comparisons are REG_AW bits only.

Decomposition:
- Shared package: REG_AW default; the SEL_RF/SEL_MEM/SEL_WB/SEL_HOLD codes (00/01/10/11); the slot struct typedef {valid, dst, wr_en, is_load}.
- One natural sub-module: fwd_match_prio. It takes one source register, its use bit and the three slots, and returns the 2-bit select plus an EX-load-hit flag. It is instantiated twice, once per operand.

Test Plan:
- ADD r1 issued, then next cycle SUB using r1 as src_a → sel_a=01 in SUB's EX cycle, sel_b=00, stall=0.
- Producer r2 two ahead and three ahead, with consumer src_b=r2 → sel_b=10, then sel_b=11 respectively. With r2 written by both S_EX and S_WB → sel_b=01 (youngest wins).
- LOAD r3 immediately followed by a consumer of r3 → stall=1 for exactly 1 cycle. Next cycle stall=0 and the following EX cycle has sel=10.
- Producer writing r0 with ZERO_REG_HW=1, consumer src_a=r0 → sel_a=00, no stall even if the producer is a load. Same source on both operands → identical selects.
- Load-use hazard with flush=1 in the same cycle → stall=0, the killed instruction does not enter S_EX, and a later consumer sees no match from it.
- Assert reset for one cycle with the scoreboard full and a stall pending → stall=0 immediately, sel_a=sel_b=00 after the edge, and the next dependent issue gets 00.

Source files
------------

// File: rtl/fwd_select_ctrl_pkg.sv
// Shared types and select codes for the EX-stage operand forwarding controller.
// The slot struct is sized by REG_AW_DEFAULT, so modules must be built with REG_AW equal to it.
package fwd_select_ctrl_pkg;

  localparam int REG_AW_DEFAULT = 3;

  localparam logic [1:0] SEL_RF   = 2'b00;
  localparam logic [1:0] SEL_MEM  = 2'b01;
  localparam logic [1:0] SEL_WB   = 2'b10;
  localparam logic [1:0] SEL_HOLD = 2'b11;

  typedef struct packed {
    logic                      valid;
    logic [REG_AW_DEFAULT-1:0] dst;
    logic                      wr_en;
    logic                      is_load;
  } slot_t;

  localparam slot_t SLOT_EMPTY = '0;

endpackage

// File: rtl/fwd_match_prio.sv
// Picks the youngest scoreboard slot that produces one source operand and
// flags when that youngest hit is a load still in EX.
module fwd_match_prio
  import fwd_select_ctrl_pkg::*;
#(
  parameter int REG_AW      = REG_AW_DEFAULT,
  parameter int ZERO_REG_HW = 1
) (
  input  logic [REG_AW-1:0] src,
  input  logic              use_src,
  input  slot_t             slot_ex,
  input  slot_t             slot_mem,
  input  slot_t             slot_wb,
  output logic [1:0]        sel,
  output logic              ex_load_hit
);

  logic zero_blocked;
  logic hit_ex;
  logic hit_mem;
  logic hit_wb;

  function automatic logic slot_hit(input slot_t s, input logic [REG_AW-1:0] r);
    return s.valid & s.wr_en & (s.dst == r);
  endfunction

  always_comb begin
    zero_blocked = (ZERO_REG_HW != 0) && (src == '0);
    hit_ex       = use_src & !zero_blocked & slot_hit(slot_ex, src);
    hit_mem      = use_src & !zero_blocked & slot_hit(slot_mem, src);
    hit_wb       = use_src & !zero_blocked & slot_hit(slot_wb, src);
    ex_load_hit  = hit_ex & slot_ex.is_load;

    // Youngest producer wins: EX over MEM over WB.
    sel = SEL_RF;
    if (hit_ex) begin
      sel = SEL_MEM;
    end else if (hit_mem) begin
      sel = SEL_WB;
    end else if (hit_wb) begin
      sel = SEL_HOLD;
    end
  end

endmodule

// File: rtl/fwd_select_ctrl.sv
// Forwarding select and load-use stall controller beside the RR/EX register;
// selects are registered so they hold steady for the whole EX cycle.
module fwd_select_ctrl
  import fwd_select_ctrl_pkg::*;
#(
  parameter int REG_AW      = REG_AW_DEFAULT,
  parameter int ZERO_REG_HW = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              issue_valid,
  input  logic [REG_AW-1:0] issue_src_a,
  input  logic [REG_AW-1:0] issue_src_b,
  input  logic              issue_use_a,
  input  logic              issue_use_b,
  input  logic [REG_AW-1:0] issue_dst,
  input  logic              issue_wr_en,
  input  logic              issue_is_load,
  input  logic              flush,
  output logic [1:0]        sel_a,
  output logic [1:0]        sel_b,
  output logic              stall
);

  slot_t      slot_ex_q, slot_ex_d;
  slot_t      slot_mem_q, slot_mem_d;
  slot_t      slot_wb_q, slot_wb_d;
  logic [1:0] sel_a_q, sel_a_d;
  logic [1:0] sel_b_q, sel_b_d;
  logic [1:0] raw_sel_a, raw_sel_b;
  logic       ld_hit_a, ld_hit_b;
  logic       issue_go;

  fwd_match_prio #(.REG_AW(REG_AW), .ZERO_REG_HW(ZERO_REG_HW)) u_match_a (
    .src         (issue_src_a),
    .use_src     (issue_use_a),
    .slot_ex     (slot_ex_q),
    .slot_mem    (slot_mem_q),
    .slot_wb     (slot_wb_q),
    .sel         (raw_sel_a),
    .ex_load_hit (ld_hit_a)
  );

  fwd_match_prio #(.REG_AW(REG_AW), .ZERO_REG_HW(ZERO_REG_HW)) u_match_b (
    .src         (issue_src_b),
    .use_src     (issue_use_b),
    .slot_ex     (slot_ex_q),
    .slot_mem    (slot_mem_q),
    .slot_wb     (slot_wb_q),
    .sel         (raw_sel_b),
    .ex_load_hit (ld_hit_b)
  );

  // Flush and reset both override the load-use stall; a stalled or killed
  // instruction leaves a bubble in EX with register-file selects.
  always_comb begin
    stall    = !reset & issue_valid & !flush & (ld_hit_a | ld_hit_b);
    issue_go = issue_valid & !stall & !flush;

    slot_ex_d = SLOT_EMPTY;
    if (issue_go) begin
      slot_ex_d = '{valid: 1'b1, dst: issue_dst, wr_en: issue_wr_en, is_load: issue_is_load};
    end
    slot_mem_d = slot_ex_q;
    slot_wb_d  = slot_mem_q;

    sel_a_d = issue_go ? raw_sel_a : SEL_RF;
    sel_b_d = issue_go ? raw_sel_b : SEL_RF;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      slot_ex_q  <= SLOT_EMPTY;
      slot_mem_q <= SLOT_EMPTY;
      slot_wb_q  <= SLOT_EMPTY;
      sel_a_q    <= SEL_RF;
      sel_b_q    <= SEL_RF;
    end else begin
      slot_ex_q  <= slot_ex_d;
      slot_mem_q <= slot_mem_d;
      slot_wb_q  <= slot_wb_d;
      sel_a_q    <= sel_a_d;
      sel_b_q    <= sel_b_d;
    end
  end

  assign sel_a = sel_a_q;
  assign sel_b = sel_b_q;

endmodule

// File: tb/tb_fwd_select_ctrl.sv
// Directed bench for fwd_select_ctrl: each issue checks the same-cycle stall
// and the selects registered for that instruction's EX cycle.
module tb_fwd_select_ctrl;

  logic       clk;
  logic       reset;
  logic       issue_valid;
  logic [2:0] issue_src_a;
  logic [2:0] issue_src_b;
  logic       issue_use_a;
  logic       issue_use_b;
  logic [2:0] issue_dst;
  logic       issue_wr_en;
  logic       issue_is_load;
  logic       flush;
  logic [1:0] sel_a;
  logic [1:0] sel_b;
  logic       stall;

  int checkCount;
  int passCount;

  fwd_select_ctrl #(.REG_AW(3), .ZERO_REG_HW(1)) dut (
    .clk           (clk),
    .reset         (reset),
    .issue_valid   (issue_valid),
    .issue_src_a   (issue_src_a),
    .issue_src_b   (issue_src_b),
    .issue_use_a   (issue_use_a),
    .issue_use_b   (issue_use_b),
    .issue_dst     (issue_dst),
    .issue_wr_en   (issue_wr_en),
    .issue_is_load (issue_is_load),
    .flush         (flush),
    .sel_a         (sel_a),
    .sel_b         (sel_b),
    .stall         (stall)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [1:0] actual, input logic [1:0] expected);
    checkCount++;
    if (actual === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %b, expected %b", tag, actual, expected);
    end
  endtask

  // Drives one RR-stage request a little after the edge, checks the stall
  // before the next edge and the registered selects just after it.
  task automatic applyStimulus(input string tag, input logic v, input logic [2:0] sa,
                               input logic [2:0] sb, input logic ua, input logic ub,
                               input logic [2:0] dst, input logic wr, input logic ld,
                               input logic fl, input logic expStall,
                               input logic [1:0] expA, input logic [1:0] expB);
    issue_valid   = v;
    issue_src_a   = sa;
    issue_src_b   = sb;
    issue_use_a   = ua;
    issue_use_b   = ub;
    issue_dst     = dst;
    issue_wr_en   = wr;
    issue_is_load = ld;
    flush         = fl;
    #1;
    checkOutput({tag, ".stall"}, {1'b0, stall}, {1'b0, expStall});
    @(posedge clk);
    #1;
    checkOutput({tag, ".sel_a"}, sel_a, expA);
    checkOutput({tag, ".sel_b"}, sel_b, expB);
  endtask

  task automatic idleCycles(input int n);
    issue_valid = 1'b0;
    flush       = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    checkCount    = 0;
    passCount     = 0;
    reset         = 1'b1;
    issue_valid   = 1'b0;
    issue_src_a   = 3'd0;
    issue_src_b   = 3'd0;
    issue_use_a   = 1'b0;
    issue_use_b   = 1'b0;
    issue_dst     = 3'd0;
    issue_wr_en   = 1'b0;
    issue_is_load = 1'b0;
    flush         = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset.sel_a", sel_a, 2'b00);
    checkOutput("reset.sel_b", sel_b, 2'b00);
    checkOutput("reset.stall", {1'b0, stall}, 2'b00);
    reset = 1'b0;

    // Back-to-back dependence: producer one ahead is in MEM during consumer EX.
    applyStimulus("add_r1", 1, 3'd4, 3'd5, 1, 1, 3'd1, 1, 0, 0, 0, 2'b00, 2'b00);
    applyStimulus("sub_r1", 1, 3'd1, 3'd6, 1, 1, 3'd7, 0, 0, 0, 0, 2'b01, 2'b00);
    idleCycles(3);

    applyStimulus("p2_two", 1, 3'd4, 3'd5, 1, 1, 3'd2, 1, 0, 0, 0, 2'b00, 2'b00);
    idleCycles(1);
    applyStimulus("c2_two", 1, 3'd6, 3'd2, 1, 1, 3'd0, 0, 0, 0, 0, 2'b00, 2'b10);
    idleCycles(3);

    applyStimulus("p2_three", 1, 3'd4, 3'd5, 1, 1, 3'd2, 1, 0, 0, 0, 2'b00, 2'b00);
    idleCycles(2);
    applyStimulus("c2_three", 1, 3'd6, 3'd2, 1, 1, 3'd0, 0, 0, 0, 0, 2'b00, 2'b11);
    idleCycles(3);

    applyStimulus("p2_old", 1, 3'd4, 3'd5, 1, 1, 3'd2, 1, 0, 0, 0, 2'b00, 2'b00);
    idleCycles(1);
    applyStimulus("p2_new", 1, 3'd4, 3'd5, 1, 1, 3'd2, 1, 0, 0, 0, 2'b00, 2'b00);
    applyStimulus("c2_young", 1, 3'd6, 3'd2, 1, 1, 3'd0, 0, 0, 0, 0, 2'b00, 2'b01);
    idleCycles(3);

    // Load-use: one stall cycle, then the load is forwarded from WB.
    applyStimulus("ld_r3", 1, 3'd4, 3'd5, 1, 1, 3'd3, 1, 1, 0, 0, 2'b00, 2'b00);
    applyStimulus("use_r3_stall", 1, 3'd3, 3'd6, 1, 1, 3'd0, 0, 0, 0, 1, 2'b00, 2'b00);
    applyStimulus("use_r3_go", 1, 3'd3, 3'd6, 1, 1, 3'd0, 0, 0, 0, 0, 2'b10, 2'b00);
    idleCycles(3);

    applyStimulus("ld_r0", 1, 3'd4, 3'd5, 1, 1, 3'd0, 1, 1, 0, 0, 2'b00, 2'b00);
    applyStimulus("use_r0", 1, 3'd0, 3'd0, 1, 1, 3'd0, 0, 0, 0, 0, 2'b00, 2'b00);
    idleCycles(3);

    applyStimulus("p5", 1, 3'd4, 3'd6, 1, 1, 3'd5, 1, 0, 0, 0, 2'b00, 2'b00);
    applyStimulus("same_src", 1, 3'd5, 3'd5, 1, 1, 3'd0, 0, 0, 0, 0, 2'b01, 2'b01);
    idleCycles(3);

    applyStimulus("unused_src", 1, 3'd4, 3'd6, 1, 1, 3'd5, 1, 0, 0, 0, 2'b00, 2'b00);
    applyStimulus("use_off", 1, 3'd5, 3'd5, 0, 0, 3'd0, 0, 0, 0, 0, 2'b00, 2'b00);
    idleCycles(3);

    // Flushed consumer of a load: no stall and it must not land in EX.
    applyStimulus("ld_r4", 1, 3'd1, 3'd2, 1, 1, 3'd4, 1, 1, 0, 0, 2'b00, 2'b00);
    applyStimulus("flush_use", 1, 3'd4, 3'd1, 1, 1, 3'd6, 1, 0, 1, 0, 2'b00, 2'b00);
    applyStimulus("after_flush", 1, 3'd6, 3'd4, 1, 1, 3'd0, 0, 0, 0, 0, 2'b00, 2'b10);
    idleCycles(3);

    // Reset with a full scoreboard and a pending load-use stall.
    applyStimulus("fill_r1", 1, 3'd4, 3'd5, 1, 1, 3'd1, 1, 0, 0, 0, 2'b00, 2'b00);
    applyStimulus("fill_r2", 1, 3'd4, 3'd5, 1, 1, 3'd2, 1, 0, 0, 0, 2'b00, 2'b00);
    applyStimulus("fill_ld3", 1, 3'd4, 3'd5, 1, 1, 3'd3, 1, 1, 0, 0, 2'b00, 2'b00);
    issue_valid   = 1'b1;
    issue_src_a   = 3'd3;
    issue_src_b   = 3'd2;
    issue_use_a   = 1'b1;
    issue_use_b   = 1'b1;
    issue_dst     = 3'd0;
    issue_wr_en   = 1'b0;
    issue_is_load = 1'b0;
    flush         = 1'b0;
    #1;
    checkOutput("pre_reset.stall", {1'b0, stall}, 2'b01);
    reset = 1'b1;
    #1;
    checkOutput("in_reset.stall", {1'b0, stall}, 2'b00);
    @(posedge clk);
    #1;
    checkOutput("post_reset.sel_a", sel_a, 2'b00);
    checkOutput("post_reset.sel_b", sel_b, 2'b00);
    reset = 1'b0;
    applyStimulus("after_reset", 1, 3'd3, 3'd2, 1, 1, 3'd0, 0, 0, 0, 0, 2'b00, 2'b00);
    idleCycles(2);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
